// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and data memory: validates the request, runs a
// three-state handshake with the memory and returns extended load data to MEM/WB.
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ALU_OUTPUT,
    input  logic [31:0] DATA2,
    output logic        DMEM_READ,
    output logic        DMEM_WRITE,
    output logic [31:0] DMEM_ADDRESS,
    output logic [31:0] DMEM_WRITEDATA,
    output logic [3:0]  DMEM_BYTE_EN,
    input  logic [31:0] DMEM_READDATA,
    input  logic        DMEM_BUSY,
    output logic        STALL,
    output logic [31:0] LOAD_DATA,
    output logic        LOAD_VALID,
    output logic        ACCESS_FAULT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    state_t      next_state;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data_q;
    logic [3:0]  byte_en_q;
    logic [2:0]  funct3_q;
    logic        is_write_q;
    logic [7:0]  wait_cnt;
    logic        timeout_q;
    logic        fault_q;

    logic        funct3_ok;
    logic        aligned;
    logic        accept;
    logic        reject;
    logic        wait_expired;
    logic [3:0]  st_byte_en;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Request qualification: BU/HU exist only for loads, and exactly one direction may be set.
    always_comb begin
        funct3_ok = 1'b0;
        case (FUNCT3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = MEM_READ;
            default:                funct3_ok = 1'b0;
        endcase

        aligned = 1'b1;
        case (FUNCT3[1:0])
            2'b01:   aligned = ~ALU_OUTPUT[0];
            2'b10:   aligned = (ALU_OUTPUT[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        accept = (MEM_READ ^ MEM_WRITE) & funct3_ok & aligned;
        reject = (MEM_READ | MEM_WRITE) & ~accept;
    end

    always_comb begin
        st_byte_en = 4'b1111;
        st_wdata   = DATA2;
        case (FUNCT3[1:0])
            2'b00: begin
                st_byte_en = 4'b0001 << ALU_OUTPUT[1:0];
                st_wdata   = {4{DATA2[7:0]}};
            end
            2'b01: begin
                st_byte_en = 4'b0011 << {ALU_OUTPUT[1], 1'b0};
                st_wdata   = {2{DATA2[15:0]}};
            end
            default: begin
                st_byte_en = 4'b1111;
                st_wdata   = DATA2;
            end
        endcase
    end

    always_comb begin
        ld_byte = DMEM_READDATA[7:0];
        case (addr_q[1:0])
            2'b00: ld_byte = DMEM_READDATA[7:0];
            2'b01: ld_byte = DMEM_READDATA[15:8];
            2'b10: ld_byte = DMEM_READDATA[23:16];
            2'b11: ld_byte = DMEM_READDATA[31:24];
            default: ld_byte = DMEM_READDATA[7:0];
        endcase
        ld_half = addr_q[1] ? DMEM_READDATA[31:16] : DMEM_READDATA[15:0];

        ld_value = DMEM_READDATA;
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b101:  ld_value = {16'd0, ld_half};
            default: ld_value = DMEM_READDATA;
        endcase
    end

    assign wait_expired = DMEM_BUSY && (wait_cnt == WAIT_LIMIT - 8'd1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACCESS;
            ACCESS:  if (!DMEM_BUSY || wait_expired) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            byte_en_q   <= 4'd0;
            funct3_q    <= 3'd0;
            is_write_q  <= 1'b0;
            wait_cnt    <= 8'd0;
            timeout_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            fault_q <= (state == IDLE) && reject;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= ALU_OUTPUT;
                        funct3_q   <= FUNCT3;
                        is_write_q <= MEM_WRITE;
                        byte_en_q  <= MEM_WRITE ? st_byte_en : 4'b1111;
                        wdata_q    <= MEM_WRITE ? st_wdata : 32'd0;
                        wait_cnt   <= 8'd0;
                        timeout_q  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!DMEM_BUSY) begin
                        if (!is_write_q) begin
                            load_data_q <= ld_value;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // A timed-out access leaves a defined zero on the load bus.
                        if (wait_expired) begin
                            timeout_q   <= 1'b1;
                            load_data_q <= 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // STALL is gated by RESET so a held request cannot stall the pipe while in reset.
    always_comb begin
        STALL          = 1'b0;
        DMEM_READ      = 1'b0;
        DMEM_WRITE     = 1'b0;
        DMEM_ADDRESS   = 32'd0;
        DMEM_WRITEDATA = 32'd0;
        DMEM_BYTE_EN   = 4'd0;
        LOAD_VALID     = 1'b0;
        ACCESS_FAULT   = fault_q;
        LOAD_DATA      = load_data_q;
        case (state)
            IDLE: begin
                STALL = accept & RESET;
            end
            ACCESS: begin
                STALL          = 1'b1;
                DMEM_READ      = ~is_write_q;
                DMEM_WRITE     = is_write_q;
                DMEM_ADDRESS   = {addr_q[31:2], 2'b00};
                DMEM_WRITEDATA = wdata_q;
                DMEM_BYTE_EN   = byte_en_q;
            end
            DONE: begin
                LOAD_VALID   = ~is_write_q & ~timeout_q;
                ACCESS_FAULT = fault_q | timeout_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random transactions checked
// against a transaction-level model of sizes, lanes, extension and wait timing.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 15;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ALU_OUTPUT;
    logic [31:0] DATA2;
    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic [31:0] DMEM_ADDRESS;
    logic [31:0] DMEM_WRITEDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic [31:0] DMEM_READDATA;
    logic        DMEM_BUSY;
    logic        STALL;
    logic [31:0] LOAD_DATA;
    logic        LOAD_VALID;
    logic        ACCESS_FAULT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ld = 32'd0;

    mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3),
        .ALU_OUTPUT(ALU_OUTPUT),
        .DATA2(DATA2),
        .DMEM_READ(DMEM_READ),
        .DMEM_WRITE(DMEM_WRITE),
        .DMEM_ADDRESS(DMEM_ADDRESS),
        .DMEM_WRITEDATA(DMEM_WRITEDATA),
        .DMEM_BYTE_EN(DMEM_BYTE_EN),
        .DMEM_READDATA(DMEM_READDATA),
        .DMEM_BUSY(DMEM_BUSY),
        .STALL(STALL),
        .LOAD_DATA(LOAD_DATA),
        .LOAD_VALID(LOAD_VALID),
        .ACCESS_FAULT(ACCESS_FAULT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_request();
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        FUNCT3     = 3'd0;
        ALU_OUTPUT = 32'd0;
        DATA2      = 32'd0;
        DMEM_BUSY  = 1'b0;
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        if (rd == wr) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        return (addr % size_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_byte_en(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        int n = size_bytes(f3);
        if (!wr) return 4'hF;
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d2);
        logic [31:0] w;
        int n = size_bytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d2[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int n = size_bytes(f3);
        logic [31:0] v;
        logic [31:0] mask;
        v = rdata >> (8 * (addr % 4));
        if (n < 4) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // One complete transaction, starting and ending just after a falling edge.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] d2,
                                  input logic [31:0] rdata, input int nbusy);
        bit          timeout;
        int          nacc;
        logic [31:0] exp_ld;
        MEM_READ      = rd;
        MEM_WRITE     = wr;
        FUNCT3        = f3;
        ALU_OUTPUT    = addr;
        DATA2         = d2;
        DMEM_BUSY     = 1'b0;
        DMEM_READDATA = $urandom;
        #1;
        if (!model_legal(rd, wr, f3, addr)) begin
            check_output("reject_stall", STALL, 0);
            check_output("reject_strobe", {DMEM_READ, DMEM_WRITE}, 0);
            step();
            clear_request();
            #1;
            check_output("reject_fault", ACCESS_FAULT, 1);
            check_output("reject_stall_after", STALL, 0);
            check_output("reject_strobe_after", {DMEM_READ, DMEM_WRITE}, 0);
            check_output("reject_load_valid", LOAD_VALID, 0);
            return;
        end
        check_output("accept_stall", STALL, 1);
        check_output("accept_strobe", {DMEM_READ, DMEM_WRITE}, 0);
        check_output("accept_addr_idle", DMEM_ADDRESS, 0);
        check_output("accept_load_valid", LOAD_VALID, 0);
        timeout = (nbusy >= MAX_WAIT);
        nacc    = timeout ? MAX_WAIT : nbusy + 1;
        step();
        for (int k = 0; k < nacc; k++) begin
            DMEM_BUSY     = (k < nbusy);
            DMEM_READDATA = DMEM_BUSY ? $urandom : rdata;
            #1;
            check_output("access_stall", STALL, 1);
            check_output("access_read", DMEM_READ, rd);
            check_output("access_write", DMEM_WRITE, wr);
            check_output("access_addr", DMEM_ADDRESS, addr - (addr % 4));
            check_output("access_byte_en", DMEM_BYTE_EN, model_byte_en(wr, f3, addr));
            if (wr) check_output("access_wdata", DMEM_WRITEDATA, model_wdata(f3, d2));
            check_output("access_valid", LOAD_VALID, 0);
            check_output("access_fault", ACCESS_FAULT, 0);
            step();
        end
        DMEM_BUSY = 1'b0;
        #1;
        if (timeout) exp_ld = 32'd0;
        else if (rd) exp_ld = load_value(f3, addr, rdata);
        else exp_ld = model_ld;
        model_ld = exp_ld;
        check_output("done_stall", STALL, 0);
        check_output("done_strobe", {DMEM_READ, DMEM_WRITE}, 0);
        check_output("done_addr", DMEM_ADDRESS, 0);
        check_output("done_byte_en", DMEM_BYTE_EN, 0);
        check_output("done_wdata", DMEM_WRITEDATA, 0);
        check_output("done_valid", LOAD_VALID, rd && !timeout);
        check_output("done_fault", ACCESS_FAULT, timeout);
        check_output("done_load_data", LOAD_DATA, exp_ld);
        clear_request();
        step();
        #1;
        check_output("idle_valid", LOAD_VALID, 0);
        check_output("idle_fault", ACCESS_FAULT, 0);
        check_output("idle_stall", STALL, 0);
        check_output("idle_load_data", LOAD_DATA, model_ld);
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          sel;
        int          nbusy;

        RESET = 1'b0;
        clear_request();
        DMEM_READDATA = 32'd0;
        MEM_READ      = 1'b1;
        FUNCT3        = 3'b010;
        #1;
        check_output("reset_stall", STALL, 0);
        check_output("reset_strobe", {DMEM_READ, DMEM_WRITE}, 0);
        check_output("reset_addr", DMEM_ADDRESS, 0);
        check_output("reset_wdata", DMEM_WRITEDATA, 0);
        check_output("reset_byte_en", DMEM_BYTE_EN, 0);
        check_output("reset_load_data", LOAD_DATA, 0);
        check_output("reset_flags", {LOAD_VALID, ACCESS_FAULT}, 0);
        step();
        step();
        clear_request();
        RESET = 1'b1;

        $display("[TB] LB sign extension, first request after reset");
        apply_stimulus(1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0);
        check_output("lb_value", LOAD_DATA, 32'hFFFF_FF80);

        $display("[TB] SH with three busy edges");
        apply_stimulus(0, 1, 3'b001, 32'h0000_0042, 32'hDEAD_BEEF, 32'd0, 3);

        $display("[TB] misaligned LW then legal LW");
        apply_stimulus(1, 0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0);
        apply_stimulus(1, 0, 3'b010, 32'h0000_0008, 32'd0, 32'h1357_9BDF, 1);
        check_output("lw_value", LOAD_DATA, 32'h1357_9BDF);

        $display("[TB] LHU timeout");
        apply_stimulus(1, 0, 3'b101, 32'h0000_0002, 32'd0, 32'hFFFF_FFFF, MAX_WAIT);
        check_output("timeout_load_data", LOAD_DATA, 0);

        $display("[TB] illegal encodings");
        apply_stimulus(1, 1, 3'b010, 32'h0000_0010, 32'd0, 32'd0, 0);
        apply_stimulus(0, 1, 3'b100, 32'h0000_0010, 32'd0, 32'd0, 0);
        apply_stimulus(1, 0, 3'b011, 32'h0000_0010, 32'd0, 32'd0, 0);

        $display("[TB] reset during SW access");
        MEM_WRITE  = 1'b1;
        FUNCT3     = 3'b010;
        ALU_OUTPUT = 32'h0000_0020;
        DATA2      = $urandom;
        DMEM_BUSY  = 1'b1;
        #1;
        check_output("sw_stall", STALL, 1);
        step();
        #1;
        check_output("sw_write", DMEM_WRITE, 1);
        #2;
        RESET = 1'b0;
        #1;
        check_output("abort_write", DMEM_WRITE, 0);
        check_output("abort_stall", STALL, 0);
        check_output("abort_addr", DMEM_ADDRESS, 0);
        model_ld = 32'd0;
        check_output("abort_load_data", LOAD_DATA, 0);
        step();
        check_output("abort_flags", {LOAD_VALID, ACCESS_FAULT}, 0);
        clear_request();
        RESET = 1'b1;
        apply_stimulus(1, 0, 3'b100, 32'h0000_0001, 32'd0, 32'h0000_AB00, 0);
        check_output("lbu_value", LOAD_DATA, 32'h0000_00AB);

        $display("[TB] random transactions");
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel <= 5);
            wr  = (sel == 0) || (sel >= 6);
            if ($urandom_range(0, 9) < 8) begin
                f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % size_bytes(f3));
            nbusy = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WAIT - 1, MAX_WAIT + 3)
                                                : $urandom_range(0, 3);
            apply_stimulus(rd, wr, f3, addr, $urandom, $urandom, nbusy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
